dram_rr_arbiter: RTL
====================

// Module: dram_rr_arbiter
// PURPOSE
//  Round-robin arbiter between NCORES cores and one shared single-port synchronous RAM (DRAM or IRAM).
//  Sits directly downstream of the cores' Mem_Ctrl/address/data outputs and upstream of the RAM macro.
//  Serialises accesses, returns per-core read data and per-core acquire/valid flags.
// PARAMETERS
//  NCORES  2  number of requesting cores (>=2)
//  AW      8  address width
//  DW      8  data width
// PORTS
//  clk       in   1          system clock (divided CLK), all logic on rising edge
//  rst       in   1          synchronous, active-high reset
//  rden      in   NCORES     per-core read request, level, held until acq seen
//  wren      in   NCORES     per-core write request, level, held until acq seen
//  addr      in   NCORES*AW  per-core address, core i at [i*AW +: AW]
//  din       in   NCORES*DW  per-core write data, core i at [i*DW +: DW]
//  ram_q     in   DW         RAM read data, valid one cycle after ram_addr sampled
//  acq       out  NCORES     one-hot grant, registered
//  dq        out  NCORES*DW  per-core read data holding register
//  rvalid    out  NCORES     one-cycle pulse: dq slot i updated
//  ram_addr  out  AW         RAM address
//  ram_din   out  DW         RAM write data
//  ram_wren  out  1          RAM write enable
// BEHAVIOUR
//  Reset: state=IDLE, acq=0, rvalid=0, dq=0, ram_addr=0, ram_din=0, ram_wren=0, last=NCORES-1 (core0 first).
//  req[i] = rden[i] | wren[i]; rden&wren together from one core = write (read ignored).
//  FSM IDLE -> GRANT -> (WAIT if read) -> IDLE.
//   IDLE: if any req, pick first requester scanning last+1, last+2, ... mod NCORES; register acq one-hot,
//     latch sel, is_wr; last<=sel; next GRANT. No req: stay IDLE, acq=0.
//   GRANT (1 cycle): ram_addr=addr[sel], ram_din=din[sel], ram_wren=is_wr; acq[sel]=1.
//     write -> IDLE; read -> WAIT.
//   WAIT (1 cycle): acq[sel] stays 1, ram_wren=0, ram_addr held; at end of cycle dq[sel]<=ram_q,
//     rvalid[sel]<=1 for the following cycle only; next IDLE.
//  Latency (request seen in IDLE at cycle 0): write done in RAM at end of cycle 1;
//   read data in dq with rvalid at cycle 3. Back-to-back: new arbitration in IDLE only.
//  Core must drop request in the cycle after acq falls; if still high it re-enters arbitration
//   and loses to any other requester (round-robin), wins again if alone.
//  ram_wren is never 1 outside GRANT; acq never has more than one bit set.
//  Request changes while not granted: only value sampled at the IDLE decision counts;
//   addr/din of granted core sampled combinationally in GRANT (must be stable while req held).
//  dq slots of non-granted cores are never modified.
//  rst in any state: all outputs to reset values next edge; an in-flight read returns no rvalid;
//   an in-flight write in GRANT is cancelled if rst is high that cycle (ram_wren forced 0).
// TESTING
//  1 rst 2 cycles, no req -> acq=0, rvalid=0, ram_wren=0, dq=0 for 10 cycles.
//  2 core0 wren, addr 0x10, din 0xA5 -> acq=01 cycle 1, ram_wren=1 ram_addr=0x10 ram_din=0xA5 in cycle 1 only.
//  3 core1 rden addr 0x10 after test 2 -> acq=10 cycles 1-2, rvalid=10 cycle 3, dq[15:8]=0xA5, dq[7:0] unchanged.
//  4 both cores hold rden continuously after reset -> grants alternate 0,1,0,1; no two grants overlap.
//  5 core0 rden while rst asserted in WAIT -> no rvalid, acq=0, next grant goes to core0 first.
//  6 core1 rden=wren=1 addr 0x22 din 0x5C -> treated as write, no WAIT state, no rvalid.

Source files
------------

// File: rtl/dram_rr_arbiter.sv
// dram_rr_arbiter: round-robin arbiter serialising NCORES cores onto one single-port synchronous RAM.
// Rev 1.0
`default_nettype none

module dram_rr_arbiter #(
  parameter int NCORES = 2,
  parameter int AW     = 8,
  parameter int DW     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    rden,
  input  logic [NCORES-1:0]    wren,
  input  logic [NCORES*AW-1:0] addr,
  input  logic [NCORES*DW-1:0] din,
  input  logic [DW-1:0]        ram_q,
  output logic [NCORES-1:0]    acq,
  output logic [NCORES*DW-1:0] dq,
  output logic [NCORES-1:0]    rvalid,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_din,
  output logic                 ram_wren
);

  localparam int            SW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [SW:0]   NC = (SW+1)'(NCORES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                state;
  logic [SW-1:0]         sel;
  logic [SW-1:0]         last;
  logic                  is_wr;
  logic [AW-1:0]         addr_hold;
  logic [DW-1:0]         din_hold;

  logic [AW-1:0]         addr_a [NCORES];
  logic [DW-1:0]         din_a  [NCORES];
  logic [DW-1:0]         dq_a   [NCORES];

  logic [NCORES-1:0]     req;
  logic [2*NCORES-1:0]   req2;
  logic [NCORES-1:0]     rot;
  logic [SW:0]           shamt;
  logic [SW:0]           sum;
  logic [SW-1:0]         off;
  logic [SW-1:0]         pick;
  logic                  any_req;

  generate
    for (genvar i = 0; i < NCORES; i++) begin : g_slot
      assign addr_a[i]           = addr[i*AW +: AW];
      assign din_a[i]            = din[i*DW +: DW];
      assign dq[i*DW +: DW]      = dq_a[i];
    end
  endgenerate

  // A simultaneous read+write from one core is a write.
  assign req     = rden | wren;
  assign any_req = |req;

  // Rotate the doubled request vector so bit 0 is the core after the last winner.
  assign req2  = {req, req};
  assign shamt = {1'b0, last} + (SW+1)'(1);
  assign rot   = NCORES'(req2 >> shamt);

  always_comb begin
    off = '0;
    for (int j = NCORES - 1; j >= 0; j--) begin
      if (rot[j]) off = SW'(j);
    end
  end

  assign sum  = shamt + {1'b0, off};
  assign pick = (sum >= NC) ? SW'(sum - NC) : SW'(sum);

  // RAM port follows the granted core live during GRANT, then holds its last value.
  assign ram_wren = (state == S_GRANT) && is_wr && !rst;
  assign ram_addr = (state == S_GRANT) ? addr_a[sel] : addr_hold;
  assign ram_din  = (state == S_GRANT) ? din_a[sel]  : din_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acq       <= '0;
      rvalid    <= '0;
      sel       <= '0;
      is_wr     <= 1'b0;
      last      <= SW'(NCORES - 1);
      addr_hold <= '0;
      din_hold  <= '0;
      for (int i = 0; i < NCORES; i++) dq_a[i] <= '0;
    end else begin
      rvalid <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            acq   <= NCORES'(1) << pick;
            sel   <= pick;
            is_wr <= wren[pick];
            last  <= pick;
            state <= S_GRANT;
          end else begin
            acq <= '0;
          end
        end
        S_GRANT: begin
          addr_hold <= addr_a[sel];
          din_hold  <= din_a[sel];
          if (is_wr) begin
            acq   <= '0;
            state <= S_IDLE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          dq_a[sel] <= ram_q;
          rvalid    <= NCORES'(1) << sel;
          acq       <= '0;
          state     <= S_IDLE;
        end
        default: begin
          acq   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
